// File: rtl/parity_serial_rx_pkg.sv
// ---------------------------------------------------------------------------
// parity_rx_defs -- shared definitions for the parity serial receiver.
//
// Contents:
//   rx_state_t        receiver FSM state encoding
//   DEF_CLKS_PER_BIT  default clock cycles per serial bit
//   DEF_DATA_W        default data bits per frame
//   DEF_PARITY_ODD    default parity sense (0 = even, 1 = odd)
// ---------------------------------------------------------------------------
package parity_rx_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_PARITY_ODD   = 0;

endpackage

// File: rtl/parity_serial_rx_sync.sv
// ---------------------------------------------------------------------------
// sync_2ff -- two-flop synchronizer for a single asynchronous input bit.
//
// Ports:
//   i_clk  destination clock
//   i_rst  synchronous active-high reset; both flops load RESET_VAL
//   i_d    asynchronous input
//   o_q    synchronized output (two cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make both flops sample on the same edge;
    // blocking here would collapse the chain into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/parity_serial_rx.sv
// ---------------------------------------------------------------------------
// parity_serial_rx -- oversampled serial receiver with parity and stop check.
//
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1).
//
// Ports:
//   i_clk          single rising-edge clock
//   i_rst          synchronous active-high reset
//   i_rx           serial line, idle high, asynchronous to i_clk
//   o_data         last received data word (held until the next o_valid)
//   o_valid        one-cycle pulse marking a completed frame
//   o_parity_err   parity mismatch on the last frame
//   o_frame_err    stop bit sampled low on the last frame
//   o_busy         high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module parity_serial_rx
    import parity_rx_defs::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int PARITY_ODD   = DEF_PARITY_ODD
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             PAR_REF  = (PARITY_ODD != 0);

    logic              w_rx_s;

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_busy;

    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_par_nxt;
    logic              w_frame_done;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    // Next-state logic. The counter runs freely within a bit period and is
    // cleared at every bit centre, so every sample point lands mid-bit.
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_frame_done = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end

            // Re-check the start bit half a bit later to reject glitches.
            ST_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = ST_DATA;
                        w_idx_nxt   = '0;
                        w_par_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            // LSB arrives first, so shift in from the top.
            ST_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_W-1:1]};
                    w_par_nxt   = r_par ^ w_rx_s;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_par ^ w_rx_s;
                    w_state_nxt = ST_STOP;
                end
            end

            // A low stop bit means the line may be held in break; wait for
            // it to return high before hunting for the next start bit.
            ST_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt    = '0;
                    w_frame_done = 1'b1;
                    w_state_nxt  = w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers. Outputs only change on frame completion,
    // so partial shift contents never reach o_data.
    // NOTE: the shift register and parity accumulator are reset too, so a
    // frame aborted by reset leaves no stale bits behind.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_valid <= w_frame_done;
            if (w_frame_done) begin
                r_data       <= r_shift;
                r_parity_err <= (r_par != PAR_REF);
                r_frame_err  <= ~w_rx_s;
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_parity_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_serial_rx -- self-checking bench for parity_serial_rx.
//
// Two receivers share one serial line: one configured for even parity, one
// for odd. Every frame sent pushes its expected result onto a scoreboard; a
// monitor pops and compares whenever the even receiver pulses valid, and the
// odd receiver must pulse in the same cycle with the opposite parity verdict.
// ---------------------------------------------------------------------------
module tb_parity_serial_rx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        logic          perr_odd;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          pbit;
        logic          sbit;
        int            gap;
        logic          exp_perr;
        logic          exp_ferr;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          rx;
    logic [DW-1:0] data_e;
    logic          valid_e;
    logic          perr_e;
    logic          ferr_e;
    logic          busy_e;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          perr_o;
    logic          ferr_o;
    logic          busy_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;

    parity_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_ODD(0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .o_data       (data_e),
        .o_valid      (valid_e),
        .o_parity_err (perr_e),
        .o_frame_err  (ferr_e),
        .o_busy       (busy_e)
    );

    parity_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_ODD(1)) dut_odd (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .o_data       (data_o),
        .o_valid      (valid_o),
        .o_parity_err (perr_o),
        .o_frame_err  (ferr_o),
        .o_busy       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data     = d;
        e.perr     = perr;
        e.ferr     = ferr;
        e.perr_odd = ~perr;
        sb.push_back(e);
    endtask

    // Caller is positioned #1 after a rising edge.
    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(sbit);
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(data_e), 32'h0);
        check({tag, "_valid"}, 32'(valid_e), 32'h0);
        check({tag, "_perr"},  32'(perr_e), 32'h0);
        check({tag, "_ferr"},  32'(ferr_e), 32'h0);
        check({tag, "_busy"},  32'(busy_e), 32'h0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (valid_e) begin
            check("valid_not_consecutive", 32'(prev_valid), 32'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h with empty scoreboard (t=%0t)", data_e, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_data",     32'(data_e),  32'(e.data));
                check("frame_perr",     32'(perr_e),  32'(e.perr));
                check("frame_ferr",     32'(ferr_e),  32'(e.ferr));
                check("odd_valid_sync", 32'(valid_o), 32'h1);
                check("odd_perr",       32'(perr_o),  32'(e.perr_odd));
            end
        end else if (valid_o) begin
            checks++;
            errors++;
            $display("FAIL odd_valid_alone: odd receiver pulsed without even receiver (t=%0t)", $time);
        end
        prev_valid <= valid_e;
    end

    vec_t vecs[9];
    logic saw_busy;
    logic [DW-1:0] rd;
    logic rp;

    initial begin
        // Table: {data, parity bit, stop bit, idle gap, expected perr, expected ferr}
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 3, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 3, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b1, 4, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b1, 2, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[7] = '{8'hC3, 1'b0, 1'b0, 6, 1'b0, 1'b1};
        vecs[8] = '{8'h7E, 1'b1, 1'b1, 5, 1'b1, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            push_exp(vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit, vecs[i].gap);
        end

        // Random frames; expected parity from a reference XOR.
        for (int i = 0; i < 4; i++) begin
            rd = DW'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            push_exp(rd, (^rd) ^ rp, 1'b0);
            send_frame(rd, rp, 1'b1, 2);
        end

        // Stop bit low with the line held in break.
        push_exp(8'h0F, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b0, 0);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("break_busy_high", 32'(busy_e), 32'h1);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("break_busy_released", 32'(busy_e), 32'h0);
        repeat (10) @(posedge clk);
        #1;

        // Single-cycle glitch on the idle line.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        saw_busy = 1'b0;
        repeat (CPB / 2 + 3) begin
            @(posedge clk);
            #1;
            if (busy_e) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'h1);
        check("glitch_busy_idle", 32'(busy_e), 32'h0);
        repeat (5) @(posedge clk);
        #1;

        // Reset during data bit 3 of a 0xFF frame.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("midframe_data_held", 32'(data_e), 32'h0F);
        check("midframe_busy", 32'(busy_e), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 4);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_serial_rx.md
PARITY_SERIAL_RX -- requirements
Module: parity_serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit period (even, >=4).
REQ-002 Parameter DATA_W, default 8, data bits per frame.
REQ-003 Parameter PARITY_ODD, default 0, where 0 means even parity and 1 means odd parity.
REQ-004 clk  input  1  single clock; all logic rising-edge triggered.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 data  output  DATA_W  last received data word.
REQ-008 valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 parity_err  output  1  parity mismatch on last frame.
REQ-010 frame_err  output  1  stop bit sampled low on last frame.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value rx_s.
REQ-013 Frame format SHALL be 1 start bit (0), then DATA_W data bits LSB first, then 1 parity bit, then 1 stop bit (1).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE -> START SHALL occur on the first cycle rx_s == 0; the bit counter SHALL clear.
REQ-016 In START, at count CLKS_PER_BIT/2-1 (mid-bit): rx_s == 0 -> DATA with counter cleared; rx_s == 1 -> IDLE (glitch reject, no valid).
REQ-017 DATA, PARITY and STOP SHALL sample rx_s when count reaches CLKS_PER_BIT-1, i.e. at each bit centre.
REQ-018 DATA SHALL shift each sampled bit into data[DATA_W-1] position (LSB-first assembly), increment the bit index, and go to PARITY after bit DATA_W-1.
REQ-019 Running parity SHALL be the XOR of all data bits and the parity bit; parity_err = (XOR result != PARITY_ODD).
REQ-020 At the stop sample: frame_err = ~rx_s; valid SHALL pulse high on the next cycle together with updated data, parity_err and frame_err.
REQ-021 After the stop sample, a high stop bit SHALL go to IDLE; a low stop bit SHALL go to WAIT_IDLE, which SHALL remain until rx_s == 1, then go to IDLE.
REQ-022 data, parity_err and frame_err SHALL hold their values until the next valid; internal shift contents SHALL NOT appear on data mid-frame.
REQ-023 valid SHALL never be high for two consecutive cycles.
REQ-024 A new start bit SHALL be accepted in the first IDLE cycle after STOP, so back-to-back frames are received without loss.
REQ-025 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 rst high at any clock edge SHALL force state IDLE, counters 0, synchronizer flops 1, data 0, valid 0, parity_err 0, frame_err 0, busy 0.
REQ-027 rst mid-frame SHALL abort the frame with no valid pulse; reception SHALL resume at the first start bit after rst deasserts.

Structure
REQ-028 FSM state encodings and default parameter constants SHALL live in a shared header, parity_rx_defs.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, reset value parameterized, set to 1 here).

Verification
REQ-030 CLKS_PER_BIT=4, even parity: send 0xA5, parity bit 0, stop 1 -> exactly one valid with data=0xA5, parity_err=0, frame_err=0.
REQ-031 Send 0x3C with parity bit 1 (wrong for even) -> valid with data=0x3C, parity_err=1; PARITY_ODD=1 with the same frame -> parity_err=0.
REQ-032 Send 0x0F with stop bit 0, rx held low 20 cycles -> valid with frame_err=1, busy stays high until rx returns high, and no second frame is decoded.
REQ-033 1-cycle low glitch on an idle line -> no valid, busy returns 0 within CLKS_PER_BIT/2+3 cycles.
REQ-034 rst pulsed during DATA bit 3 of a 0xFF frame -> all outputs 0 the next cycle, no valid; the following 0x81 frame is received correctly.
REQ-035 Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses in order, all error flags 0.
